// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial nibble link.
// SERIAL_TX_PARITY_EN widens the bit counter to hold the extra parity bit.
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PAR,
    DONE
  } tx_state_t;

  localparam int NBITS_LINK = 4;

  function automatic logic even_parity(input logic [15:0] word);
    return ^word;
  endfunction

  // With parity the frame carries NBITS+1 strobed bits, so bits_left must reach NBITS+1.
  function automatic int cnt_width(input int nbits);
`ifdef SERIAL_TX_PARITY_EN
    return $clog2(nbits + 2);
`else
    return $clog2(nbits + 1);
`endif
  endfunction

endpackage

// File: rtl/serial_nibble_tx_if.sv
// Load handshake and serial-side signals of the nibble transmitter.
interface serial_nibble_tx_if #(
  parameter int NBITS = 4,
  parameter int CNT_W = 3
) ();
  logic [NBITS-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bits_left;

  modport master (
    output data_in, load_valid,
    input  load_ready, ser_out, ser_valid, busy, done, bits_left
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, ser_out, ser_valid, busy, done, bits_left
  );
endinterface

// File: rtl/serial_nibble_tx.sv
// Parallel-to-serial transmitter: LSB-first, one strobed bit per clk_2 cycle.
// Optional even-parity trailer bit when SERIAL_TX_PARITY_EN is defined.
module serial_nibble_tx
  import serial_link_pkg::*;
#(
  parameter int NBITS = NBITS_LINK,
  parameter int CNT_W = cnt_width(NBITS)
) (
  input  logic                 clk_2,
  input  logic                 reset,
  serial_nibble_tx_if.slave    bus
);

  localparam logic [CNT_W-1:0] NB_C = CNT_W'(NBITS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
`ifdef SERIAL_TX_PARITY_EN
  localparam logic [CNT_W-1:0] PAR_EXTRA = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] PAR_EXTRA = '0;
`endif

  tx_state_t        state_q;
  logic [NBITS-1:0] shreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_ready_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] bits_left_q;
`ifdef SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  assign cnt_d = cnt_q - ONE_C;

  // shreg_q holds only the bits not yet on the wire; ser_out_q already carries the current one.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      ser_out_q    <= 1'b0;
      ser_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bits_left_q  <= '0;
`ifdef SERIAL_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.load_valid && load_ready_q) begin
            state_q      <= SHIFT;
            shreg_q      <= bus.data_in >> 1;
            cnt_q        <= NB_C;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
            ser_valid_q  <= 1'b1;
            ser_out_q    <= bus.data_in[0];
            bits_left_q  <= NB_C + PAR_EXTRA;
`ifdef SERIAL_TX_PARITY_EN
            par_q        <= even_parity(16'(bus.data_in));
`endif
          end
        end
        SHIFT: begin
          shreg_q <= shreg_q >> 1;
          cnt_q   <= cnt_d;
          if (cnt_q == ONE_C) begin
`ifdef SERIAL_TX_PARITY_EN
            state_q     <= PAR;
            ser_out_q   <= par_q;
            bits_left_q <= ONE_C;
`else
            state_q     <= DONE;
            ser_valid_q <= 1'b0;
            ser_out_q   <= 1'b0;
            done_q      <= 1'b1;
            bits_left_q <= '0;
`endif
          end else begin
            ser_out_q   <= shreg_q[0];
            bits_left_q <= cnt_d + PAR_EXTRA;
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PAR: begin
          state_q     <= DONE;
          ser_valid_q <= 1'b0;
          ser_out_q   <= 1'b0;
          done_q      <= 1'b1;
          bits_left_q <= '0;
        end
`endif
        DONE: begin
          state_q      <= IDLE;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
          load_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          load_ready_q <= 1'b1;
          busy_q       <= 1'b0;
          ser_valid_q  <= 1'b0;
          ser_out_q    <= 1'b0;
          done_q       <= 1'b0;
          bits_left_q  <= '0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready_q;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.bits_left  = bits_left_q;

endmodule
